// File: rtl/frame_config_writer.sv
// Column configuration frame writer: parses a sync/header/data word stream and
// drives registered FrameData plus a single-cycle one-hot FrameStrobe.
module frame_config_writer #(
    parameter int unsigned                MaxFramesPerCol = 20,
    parameter int unsigned                FrameBitsPerRow = 32,
    parameter int unsigned                ColumnId        = 0,
    parameter logic [FrameBitsPerRow-1:0] SyncWord        = 32'hFAB0_FAB1
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] word_data,
    input  logic                       word_valid,
    output logic                       word_ready,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       config_active,
    output logic                       config_done,
    output logic                       frame_error,
    output logic [15:0]                frames_written
);

    typedef enum logic [2:0] {StBoot, StIdle, StHeader, StData, StStrobe} state_e;

    state_e                     state_q, state_d;
    logic [6:0]                 col_q, col_d;
    logic [15:0]                idx_q, idx_d;
    logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic                       active_q, active_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;
    logic [15:0]                count_q, count_d;
    logic                       xfer;
    logic                       col_match;
    logic                       idx_in_range;

    assign word_ready   = (state_q == StIdle) || (state_q == StHeader) || (state_q == StData);
    assign xfer         = word_valid && word_ready;
    assign col_match    = (col_q == 7'(ColumnId));
    assign idx_in_range = (32'(idx_q) < MaxFramesPerCol);

    // Strobe, counter and error are computed on the data transfer so they are
    // registered and visible exactly in the STROBE cycle.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        idx_d        = idx_q;
        frame_data_d = frame_data_q;
        strobe_d     = '0;
        active_d     = active_q;
        done_d       = 1'b0;
        error_d      = error_q;
        count_d      = count_q;
        case (state_q)
            StBoot: state_d = StIdle;
            StIdle: begin
                if (xfer && (word_data == SyncWord)) begin
                    state_d  = StHeader;
                    active_d = 1'b1;
                    error_d  = 1'b0;
                    count_d  = '0;
                end
            end
            StHeader: begin
                if (xfer) begin
                    if (word_data[FrameBitsPerRow-1]) begin
                        state_d  = StIdle;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        col_d   = word_data[30:24];
                        idx_d   = word_data[15:0];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    frame_data_d = word_data;
                    state_d      = StStrobe;
                    if (col_match && idx_in_range) begin
                        for (int unsigned i = 0; i < MaxFramesPerCol; i++) begin
                            strobe_d[i] = (32'(idx_q) == i);
                        end
                        if (count_q != 16'hFFFF) begin
                            count_d = count_q + 16'd1;
                        end
                    end else if (col_match) begin
                        error_d = 1'b1;
                    end
                end
            end
            StStrobe: state_d = StHeader;
            default:  state_d = StBoot;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StBoot;
            col_q        <= '0;
            idx_q        <= '0;
            frame_data_q <= '0;
            strobe_q     <= '0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            idx_q        <= idx_d;
            frame_data_q <= frame_data_d;
            strobe_q     <= strobe_d;
            active_q     <= active_d;
            done_q       <= done_d;
            error_q      <= error_d;
            count_q      <= count_d;
        end
    end

    assign FrameData      = frame_data_q;
    assign FrameStrobe    = strobe_q;
    assign config_active  = active_q;
    assign config_done    = done_q;
    assign frame_error    = error_q;
    assign frames_written = count_q;

endmodule

// File: tb/tb_frame_config_writer.sv
// Randomized bench for frame_config_writer: a word-level stream parser predicts
// strobe events, counters and flags, and a negedge monitor collects what the DUT does.
module tb_frame_config_writer;

    localparam int unsigned NF   = 20;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
    localparam logic [31:0] ENDW = 32'h8000_0000;

    logic          CLK = 1'b0;
    logic          resetn = 1'b1;
    logic [31:0]   word_data = '0;
    logic          word_valid = 1'b0;
    logic          word_ready;
    logic [31:0]   FrameData;
    logic [NF-1:0] FrameStrobe;
    logic          config_active;
    logic          config_done;
    logic          frame_error;
    logic [15:0]   frames_written;

    always #5 CLK = ~CLK;

    frame_config_writer #(
        .MaxFramesPerCol(NF),
        .FrameBitsPerRow(32),
        .ColumnId       (0),
        .SyncWord       (SYNC)
    ) dut (
        .CLK           (CLK),
        .resetn        (resetn),
        .word_data     (word_data),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .FrameData     (FrameData),
        .FrameStrobe   (FrameStrobe),
        .config_active (config_active),
        .config_done   (config_done),
        .frame_error   (frame_error),
        .frames_written(frames_written)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: interprets accepted words as a sync/header/data/end stream.
    int          m_mode;     // 0 = hunting sync, 1 = expect header/end, 2 = expect data
    bit          m_active;
    bit          m_error;
    int          m_written;
    int          m_done;
    int          m_col;
    int          m_idx;
    int          exp_idx[$];
    int          exp_cyc[$];
    logic [31:0] exp_dat[$];
    int          act_idx[$];
    int          act_cyc[$];
    logic [31:0] act_dat[$];
    int          act_done;
    int          cyc = 0;
    bit          prev_strobe = 1'b0;

    task automatic model_reset();
        m_mode = 0; m_active = 0; m_error = 0; m_written = 0; m_done = 0; act_done = 0;
        exp_idx.delete(); exp_cyc.delete(); exp_dat.delete();
        act_idx.delete(); act_cyc.delete(); act_dat.delete();
    endtask

    task automatic model_word(input logic [31:0] w, input int c);
        if (m_mode == 0) begin
            if (w == SYNC) begin
                m_mode = 1; m_active = 1; m_error = 0; m_written = 0;
            end
        end else if (m_mode == 1) begin
            if (w[31]) begin
                m_mode = 0; m_active = 0; m_done++;
            end else begin
                m_col = int'(w[30:24]); m_idx = int'(w[15:0]); m_mode = 2;
            end
        end else begin
            m_mode = 1;
            if (m_col == 0) begin
                if (m_idx < NF) begin
                    exp_idx.push_back(m_idx); exp_dat.push_back(w); exp_cyc.push_back(c + 1);
                    m_written++;
                end else begin
                    m_error = 1;
                end
            end
        end
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (config_done) act_done++;
        if (word_valid && word_ready) model_word(word_data, cyc);
        if (FrameStrobe != '0) begin
            check("strobe_onehot", $countones(FrameStrobe), 1);
            check("strobe_back_to_back", prev_strobe, 0);
            check("ready_in_strobe", word_ready, 0);
            for (int i = 0; i < NF; i++) begin
                if (FrameStrobe[i]) begin
                    act_idx.push_back(i); act_dat.push_back(FrameData); act_cyc.push_back(cyc);
                end
            end
        end
        prev_strobe = (FrameStrobe != '0);
    end

    task automatic send(input logic [31:0] w, input int gap);
        int n = 0;
        word_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge CLK);
            #1;
        end
        word_data  = w;
        word_valid = 1'b1;
        do begin
            @(negedge CLK);
            n++;
        end while (!word_ready && n < 100);
        if (!word_ready) begin
            check("ready_timeout", 0, 1);
            word_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        word_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [31:0] dat, input int gap);
        send(hdr, gap);
        send(dat, gap);
    endtask

    task automatic apply_reset();
        #1 resetn = 1'b0;
        word_valid = 1'b0;
        model_reset();
        #1;
        check("rst_ready", word_ready, 0);
        check("rst_framedata", FrameData, 0);
        check("rst_strobe", FrameStrobe, 0);
        check("rst_active", config_active, 0);
        check("rst_done", config_done, 0);
        check("rst_error", frame_error, 0);
        check("rst_written", frames_written, 0);
        repeat (3) @(posedge CLK);
        #2 resetn = 1'b1;
        check("boot_ready", word_ready, 0);
        @(posedge CLK);
        #1;
        check("idle_ready", word_ready, 1);
    endtask

    task automatic compare_phase(input string tag);
        repeat (4) @(posedge CLK);
        #2;
        check({tag, "_nstrobe"}, act_idx.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size() && i < act_idx.size(); i++) begin
            check({tag, "_idx"}, act_idx[i], exp_idx[i]);
            check({tag, "_data"}, act_dat[i], exp_dat[i]);
            check({tag, "_cycle"}, act_cyc[i], exp_cyc[i]);
        end
        check({tag, "_written"}, frames_written, m_written);
        check({tag, "_error"}, frame_error, m_error);
        check({tag, "_active"}, config_active, m_active);
        check({tag, "_done_pulses"}, act_done, m_done);
        exp_idx.delete(); exp_cyc.delete(); exp_dat.delete();
        act_idx.delete(); act_cyc.delete(); act_dat.delete();
    endtask

    initial begin
        apply_reset();

        send(32'h1234_5678, 0);
        send(32'h0000_0000, 1);
        check("garbage_active", config_active, 0);
        compare_phase("garbage");

        send(SYNC, 0);
        send_frame(32'h0000_0003, 32'hDEAD_BEEF, 0);
        send(ENDW, 0);
        compare_phase("basic");

        send(SYNC, 0);
        send_frame(32'h0500_0002, 32'h5555_AAAA, 0);
        send(ENDW, 0);
        compare_phase("other_col");

        send(SYNC, 0);
        send_frame(32'h0000_0014, 32'h0BAD_F00D, 0);
        send(ENDW, 0);
        compare_phase("idx_range");
        send(SYNC, 2);
        compare_phase("error_clear");
        send(ENDW, 0);

        send(SYNC, 0);
        for (int i = 0; i < NF; i++) send_frame(32'(i), $urandom, 0);
        if (act_cyc.size() == NF) check("throughput", act_cyc[NF-1] - act_cyc[0], 3 * (NF - 1));
        send(ENDW, 0);
        compare_phase("burst");

        send(SYNC, 1);
        for (int i = 0; i < NF; i++) send_frame(32'(i), $urandom, $urandom_range(0, 3));
        send(ENDW, 1);
        compare_phase("gapped");

        send(SYNC, 0);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] hdr;
            hdr = {1'b0, (($urandom % 4) == 0) ? 7'd3 : 7'd0, 8'($urandom),
                   16'($urandom_range(0, 23))};
            if (($urandom % 20) == 0) hdr = SYNC;
            send_frame(hdr, $urandom, $urandom_range(0, 2));
        end
        send(ENDW, 0);
        compare_phase("random");

        send(SYNC, 0);
        send_frame(32'h0000_0003, 32'hCAFE_0003, 0);
        send_frame(32'h0000_0014, 32'hCAFE_0014, 0);
        send(32'h0000_0007, 0);
        compare_phase("pre_reset");
        apply_reset();
        send_frame(32'h0000_0007, 32'h7777_7777, 0);
        compare_phase("post_reset_nosync");
        send(SYNC, 0);
        send_frame(32'h0000_0007, 32'h7777_7777, 0);
        send(ENDW, 0);
        compare_phase("resync");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
